// File: rtl/eth10_tx_mac_phy.sv
// eth10_tx_mac_phy: 10BASE-T transmit engine. Manchester-encodes a byte
// stream LSB first, appends TP_IDL, sends Normal Link Pulses while idle and
// holds both legs low when silent. Every wire change lands on the clock edge
// that ends a half-bit strobe cycle.
// Build option: define ETH10_TX_PREAMBLE_EN to have the block insert
// 7x0x55 + 0xD5 ahead of the first source byte.
//
// state | meaning
// IDLE  | pair silent, accepting a first byte, timing the next link pulse
// PRE   | sending preamble + SFD, first byte parked in the load register
// DATA  | sending the load register, 16 half-bits per byte
// TPIDL | holding tx_p high after the last bit
// NLP   | link pulse on the wire
module eth10_tx_mac_phy #(
   parameter int HALF_DIV     = 2,
   parameter int TPIDL_HB     = 6,
   parameter int NLP_HB       = 320000,
   parameter int NLP_WIDTH_HB = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_underrun,
   output logic       nlp_pulse,
   output logic       tx_p,
   output logic       tx_n
);
   localparam int HB_W     = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int NLP_W    = $clog2(NLP_HB + 1);
   localparam int CNT_MAX0 = (TPIDL_HB > 128) ? TPIDL_HB : 128;
   localparam int CNT_MAX  = (NLP_WIDTH_HB > CNT_MAX0) ? NLP_WIDTH_HB : CNT_MAX0;
   localparam int IDX_W    = $clog2(CNT_MAX + 1);

   localparam logic [HB_W-1:0]  HB_LAST   = HB_W'(HALF_DIV - 1);
   localparam logic [NLP_W-1:0] NLP_LAST  = NLP_W'(NLP_HB - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_BYTE  = IDX_W'(16);
   localparam logic [IDX_W-1:0] IDX_TPIDL = IDX_W'(TPIDL_HB);
   localparam logic [IDX_W-1:0] IDX_NLP   = IDX_W'(NLP_WIDTH_HB);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_TPIDL, S_NLP} state_t;

   state_t            state, state_nxt;
   logic [HB_W-1:0]   hb_cnt;
   logic              strobe;
   logic              rdy_en;
   logic              p_q, p_nxt, drv_q, drv_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [NLP_W-1:0]  nlp_cnt, nlp_nxt;
   logic [7:0]        byte_q, byte_nxt;
   logic              last_q, last_nxt;
   logic              byte_end;

   // Half-bit k of a byte: first half carries ~bit, second half carries bit.
   function automatic logic data_hb(input logic [7:0] b, input logic [3:0] k);
      data_hb = k[0] ? b[k[3:1]] : ~b[k[3:1]];
   endfunction

`ifdef ETH10_TX_PREAMBLE_EN
   localparam logic [IDX_W-1:0] IDX_PRE = IDX_W'(128);

   // 0x55 has every even bit set; the SFD 0xD5 also sets bit 7 of byte 7.
   function automatic logic pre_hb(input logic [6:0] k);
      logic bit_v;
      bit_v  = ~k[1] | (k[6:4] == 3'd7 && k[3:1] == 3'd7);
      pre_hb = k[0] ? bit_v : ~bit_v;
   endfunction
`endif

   assign strobe = (hb_cnt == HB_LAST);
   assign tx_p   = p_q;
   assign tx_n   = drv_q & ~p_q;

   // Free-running half-bit divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      hb_cnt <= '0;
      else if (strobe) hb_cnt <= '0;
      else             hb_cnt <= hb_cnt + 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state plus next wire level and counters.
   always_comb begin
      state_nxt = state;
      p_nxt     = p_q;
      drv_nxt   = drv_q;
      idx_nxt   = idx;
      nlp_nxt   = nlp_cnt;
      byte_nxt  = byte_q;
      last_nxt  = last_q;
      case (state)
         S_IDLE: begin
            if (tx_ready && tx_valid) begin
               byte_nxt = tx_data;
               last_nxt = tx_last;
               nlp_nxt  = '0;
               idx_nxt  = '0;
`ifdef ETH10_TX_PREAMBLE_EN
               state_nxt = S_PRE;
               if (strobe) begin
                  p_nxt   = pre_hb(7'd0);
                  drv_nxt = 1'b1;
                  idx_nxt = IDX_ONE;
               end
`else
               state_nxt = S_DATA;
               if (strobe) begin
                  p_nxt   = data_hb(tx_data, 4'd0);
                  drv_nxt = 1'b1;
                  idx_nxt = IDX_ONE;
               end
`endif
            end else if (strobe) begin
               if (nlp_cnt == NLP_LAST) begin
                  state_nxt = S_NLP;
                  p_nxt     = 1'b1;
                  drv_nxt   = 1'b1;
                  idx_nxt   = IDX_ONE;
                  nlp_nxt   = '0;
               end else begin
                  nlp_nxt = nlp_cnt + 1'b1;
               end
            end
         end
`ifdef ETH10_TX_PREAMBLE_EN
         S_PRE: begin
            if (strobe) begin
               drv_nxt = 1'b1;
               if (idx == IDX_PRE) begin
                  state_nxt = S_DATA;
                  p_nxt     = data_hb(byte_q, 4'd0);
                  idx_nxt   = IDX_ONE;
               end else begin
                  p_nxt   = pre_hb(idx[6:0]);
                  idx_nxt = idx + 1'b1;
               end
            end
         end
`endif
         S_DATA: begin
            if (strobe) begin
               drv_nxt = 1'b1;
               if (idx == IDX_BYTE) begin
                  idx_nxt = IDX_ONE;
                  if (byte_end && tx_valid) begin
                     byte_nxt = tx_data;
                     last_nxt = tx_last;
                     p_nxt    = data_hb(tx_data, 4'd0);
                  end else begin
                     state_nxt = S_TPIDL;
                     p_nxt     = 1'b1;
                  end
               end else begin
                  p_nxt   = data_hb(byte_q, idx[3:0]);
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         S_TPIDL, S_NLP: begin
            if (strobe) begin
               if (idx == ((state == S_TPIDL) ? IDX_TPIDL : IDX_NLP)) begin
                  state_nxt = S_IDLE;
                  p_nxt     = 1'b0;
                  drv_nxt   = 1'b0;
                  idx_nxt   = '0;
                  nlp_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state.
   always_comb begin
      byte_end    = (state == S_DATA) && strobe && (idx == IDX_BYTE) && !last_q;
      tx_ready    = ((state == S_IDLE) && rdy_en) || byte_end;
      tx_underrun = byte_end && !tx_valid;
      tx_busy     = (state == S_PRE) || (state == S_DATA) || (state == S_TPIDL);
      nlp_pulse   = (state == S_NLP);
   end

   // Wire level, counters and load register; rdy_en keeps tx_ready low for
   // the first cycle out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en  <= 1'b0;
         p_q     <= 1'b0;
         drv_q   <= 1'b0;
         idx     <= '0;
         nlp_cnt <= '0;
         byte_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         rdy_en  <= 1'b1;
         p_q     <= p_nxt;
         drv_q   <= drv_nxt;
         idx     <= idx_nxt;
         nlp_cnt <= nlp_nxt;
         byte_q  <= byte_nxt;
         last_q  <= last_nxt;
      end
   end
endmodule
